sr_flag_bank_arbiter: RTL and testbench

Owns a bank of NFLAGS S-R flags with q/q_bar outputs, and shares it between NREQ requesters through round-robin arbitration. Each granted command applies S-R semantics (hold/clear/set) to one flag. The illegal S=R=1 case is trapped and reported, never propagated as X. It sits between multiple control agents and the S-R state storage, and is the single writer of that state.

---
 rtl/sr_flag_bank_arbiter_if.sv | 27 ++
 rtl/sr_flag_bank_arbiter.sv | 120 ++++++++++++
 tb/tb_sr_flag_bank_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_flag_bank_arbiter_if.sv
// Requester-side bus of the S-R flag bank arbiter: per-requester commands in,
// one-hot completion pulses and the flag bank state out.
interface sr_flag_bank_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  parameter int IDXW   = 3
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_s;
  logic [NREQ-1:0]      req_r;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      err;
  logic                 busy;
  logic [NFLAGS-1:0]    q;
  logic [NFLAGS-1:0]    q_bar;

  modport master (
    output req, req_s, req_r, req_idx,
    input  gnt, err, busy, q, q_bar
  );

  modport slave (
    input  req, req_s, req_r, req_idx,
    output gnt, err, busy, q, q_bar
  );
endinterface

// File: rtl/sr_flag_bank_arbiter.sv
// Round-robin shared S-R flag bank: one granted command per two cycles,
// illegal S=R=1 and out-of-range indices are rejected with an err pulse.
module sr_flag_bank_arbiter #(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  parameter int IDXW   = 3
) (
  input logic                   clk,
  input logic                   reset,
  sr_flag_bank_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, APPLY} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     ptr, ptr_next;
  logic [PW-1:0]     win;
  logic              win_found;
  logic [PW-1:0]     cand;
  int                sum;

  logic [PW-1:0]     w_p0;
  logic              s_p0, r_p0;
  logic [IDXW-1:0]   idx_p0;

  logic [NREQ-1:0]   gnt, err;
  logic              busy;
  logic [NFLAGS-1:0] q, q_bar, q_next;

  function automatic logic cmd_illegal(input logic s, input logic r,
                                       input logic [IDXW-1:0] idx);
    cmd_illegal = (s && r) || (int'(idx) >= NFLAGS);
  endfunction

  function automatic logic [NFLAGS-1:0] apply_cmd(input logic [NFLAGS-1:0] cur,
                                                  input logic s, input logic r,
                                                  input logic [IDXW-1:0] idx);
    apply_cmd = cur;
    if (!cmd_illegal(s, r, idx) && (s ^ r))
      apply_cmd[idx] = s;
  endfunction

  // Scan ptr, ptr+1, ... with wrap; first requester found wins.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    sum       = 0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = sum[PW-1:0];
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_next = APPLY;
          ptr_next   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        end
      end
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign q_next = apply_cmd(q, s_p0, r_p0, idx_p0);

  // p0: command latched at the IDLE->APPLY edge, applied at the APPLY->IDLE edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      err    <= '0;
      busy   <= 1'b0;
      q      <= '0;
      q_bar  <= '1;
      w_p0   <= '0;
      s_p0   <= 1'b0;
      r_p0   <= 1'b0;
      idx_p0 <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      busy  <= (state_next == APPLY);
      gnt   <= '0;
      err   <= '0;
      if (state == IDLE && win_found) begin
        w_p0   <= win;
        s_p0   <= bus.req_s[win];
        r_p0   <= bus.req_r[win];
        idx_p0 <= bus.req_idx[win*IDXW +: IDXW];
      end
      if (state == APPLY) begin
        gnt[w_p0] <= 1'b1;
        err[w_p0] <= cmd_illegal(s_p0, r_p0, idx_p0);
        q         <= q_next;
        q_bar     <= ~q_next;
      end
    end
  end

  assign bus.gnt   = gnt;
  assign bus.err   = err;
  assign bus.busy  = busy;
  assign bus.q     = q;
  assign bus.q_bar = q_bar;

endmodule

// File: tb/tb_sr_flag_bank_arbiter.sv
// Directed and model-checked bench for sr_flag_bank_arbiter (NFLAGS=8 main
// instance plus an NFLAGS=6 instance for out-of-range index rejection).
module tb_sr_flag_bank_arbiter;

  localparam int NREQ = 4;
  localparam int IDXW = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sr_flag_bank_arbiter_if #(.NREQ(NREQ), .NFLAGS(8), .IDXW(IDXW)) bus ();
  sr_flag_bank_arbiter_if #(.NREQ(NREQ), .NFLAGS(6), .IDXW(IDXW)) bus6 ();

  sr_flag_bank_arbiter #(.NREQ(NREQ), .NFLAGS(8), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  sr_flag_bank_arbiter #(.NREQ(NREQ), .NFLAGS(6), .IDXW(IDXW)) dut6 (
    .clk(clk), .reset(reset), .bus(bus6)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cmd(input int i, input logic s, input logic r, input int idx);
    logic [IDXW-1:0] iv;
    iv = idx[IDXW-1:0];
    bus.req_s[i] = s;
    bus.req_r[i] = r;
    bus.req_idx[i*IDXW +: IDXW] = iv;
    bus.req[i] = 1'b1;
  endtask

  // Drives one command from requester i and returns at the negedge showing gnt.
  task automatic issue(input int i, input logic s, input logic r, input int idx);
    set_cmd(i, s, r, idx);
    tick();
    tick();
    bus.req[i] = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_s = '0; bus.req_r = '0; bus.req_idx = '0;
    bus6.req = '0; bus6.req_s = '0; bus6.req_r = '0; bus6.req_idx = '0;
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (bus.q !== 8'h00 || bus.q_bar !== 8'hFF || bus.gnt !== 4'b0 ||
        bus.err !== 4'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: q=%h q_bar=%h gnt=%b err=%b busy=%b, want 00 ff 0000 0000 0",
               bus.q, bus.q_bar, bus.gnt, bus.err, bus.busy);
    end
    checks++;
    if (bus6.q !== 6'h00 || bus6.q_bar !== 6'h3F || bus6.gnt !== 4'b0) begin
      failures++;
      $display("FAIL reset6: q=%h q_bar=%h gnt=%b, want 00 3f 0000", bus6.q, bus6.q_bar, bus6.gnt);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    set_cmd(0, 1'b1, 1'b0, 3);
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.gnt !== 4'b0) begin
      failures++;
      $display("FAIL busy_latch: busy=%b gnt=%b, want 1 0000", bus.busy, bus.gnt);
    end
    tick();
    bus.req[0] = 1'b0;
    checks++;
    if (bus.gnt !== 4'b0001 || bus.err !== 4'b0 || bus.q !== 8'h08 || bus.q_bar !== 8'hF7) begin
      failures++;
      $display("FAIL set3: gnt=%b err=%b q=%h q_bar=%h, want 0001 0000 08 f7",
               bus.gnt, bus.err, bus.q, bus.q_bar);
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL gnt_pulse: gnt=%b busy=%b, want 0000 0", bus.gnt, bus.busy);
    end
    issue(0, 1'b0, 1'b1, 3);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.q !== 8'h00 || bus.q_bar !== 8'hFF) begin
      failures++;
      $display("FAIL clear3: gnt=%b q=%h q_bar=%h, want 0001 00 ff", bus.gnt, bus.q, bus.q_bar);
    end
    tick();
    issue(0, 1'b0, 1'b0, 3);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.err !== 4'b0 || bus.q !== 8'h00) begin
      failures++;
      $display("FAIL hold: gnt=%b err=%b q=%h, want 0001 0000 00", bus.gnt, bus.err, bus.q);
    end
    tick();
  endtask

  task automatic test_illegal();
    issue(2, 1'b1, 1'b0, 5);
    checks++;
    if (bus.q !== 8'h20) begin
      failures++;
      $display("FAIL set5: q=%h, want 20", bus.q);
    end
    tick();
    issue(2, 1'b1, 1'b1, 5);
    checks++;
    if (bus.gnt !== 4'b0100 || bus.err !== 4'b0100 || bus.q !== 8'h20 || bus.q_bar !== 8'hDF) begin
      failures++;
      $display("FAIL illegal11: gnt=%b err=%b q=%h q_bar=%h, want 0100 0100 20 df",
               bus.gnt, bus.err, bus.q, bus.q_bar);
    end
    tick();
    checks++;
    if (bus.err !== 4'b0) begin
      failures++;
      $display("FAIL err_pulse: err=%b, want 0000", bus.err);
    end
    bus6.req_s[2] = 1'b1; bus6.req_r[2] = 1'b0; bus6.req_idx[8:6] = 3'd7; bus6.req[2] = 1'b1;
    tick(); tick();
    bus6.req[2] = 1'b0;
    checks++;
    if (bus6.gnt !== 4'b0100 || bus6.err !== 4'b0100 || bus6.q !== 6'h00 || bus6.q_bar !== 6'h3F) begin
      failures++;
      $display("FAIL idx_range: gnt=%b err=%b q=%h q_bar=%h, want 0100 0100 00 3f",
               bus6.gnt, bus6.err, bus6.q, bus6.q_bar);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) set_cmd(i, 1'b1, 1'b0, i);
    for (int g = 0; g < 4; g++) begin
      tick(); tick();
      want = 4'b0001 << g;
      checks++;
      if (bus.gnt !== want) begin
        failures++;
        $display("FAIL rr_order%0d: gnt=%b, want %b", g, bus.gnt, want);
      end
      bus.req[g] = 1'b0;
    end
    checks++;
    if (bus.q !== 8'h0F) begin
      failures++;
      $display("FAIL rr_q: q=%h, want 0f", bus.q);
    end
    set_cmd(0, 1'b1, 1'b0, 0);
    set_cmd(1, 1'b1, 1'b0, 1);
    for (int g = 0; g < 4; g++) begin
      tick(); tick();
      want = (g % 2 == 0) ? 4'b0001 : 4'b0010;
      checks++;
      if (bus.gnt !== want) begin
        failures++;
        $display("FAIL rr_alt%0d: gnt=%b, want %b", g, bus.gnt, want);
      end
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset_mid_apply();
    set_cmd(1, 1'b1, 1'b0, 6);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.gnt !== 4'b0 || bus.err !== 4'b0 || bus.q !== 8'h00 || bus.q_bar !== 8'hFF || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_apply: gnt=%b err=%b q=%h q_bar=%h busy=%b, want 0000 0000 00 ff 0",
               bus.gnt, bus.err, bus.q, bus.q_bar, bus.busy);
    end
    set_cmd(3, 1'b1, 1'b0, 7);
    tick(); tick();
    bus.req[1] = 1'b0;
    checks++;
    if (bus.gnt !== 4'b0010 || bus.q !== 8'h40) begin
      failures++;
      $display("FAIL ptr_after_reset: gnt=%b q=%h, want 0010 40", bus.gnt, bus.q);
    end
    tick(); tick();
    bus.req[3] = 1'b0;
    checks++;
    if (bus.gnt !== 4'b1000 || bus.q !== 8'hC0) begin
      failures++;
      $display("FAIL second_grant: gnt=%b q=%h, want 1000 c0", bus.gnt, bus.q);
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] model;
    logic       cs [NREQ];
    logic       cr [NREQ];
    int         ci [NREQ];
    int         waitc [NREQ];
    int         w;
    logic       ill;
    logic [3:0] want_err;
    reset = 1'b1; tick(); reset = 1'b0;
    model = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      cs[i] = 1'b0; cr[i] = 1'b0; ci[i] = 0; waitc[i] = 0;
    end
    for (int cyc = 0; cyc < 1000; cyc++) begin
      tick();
      checks++;
      if (bus.q_bar !== ~bus.q) begin
        failures++;
        $display("FAIL rnd_qbar c%0d: q=%h q_bar=%h", cyc, bus.q, bus.q_bar);
      end
      checks++;
      if ($countones(bus.gnt) > 1 || (bus.err & ~bus.gnt) !== 4'b0) begin
        failures++;
        $display("FAIL rnd_onehot c%0d: gnt=%b err=%b", cyc, bus.gnt, bus.err);
      end
      if (bus.gnt !== 4'b0) begin
        w = 0;
        for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) w = i;
        checks++;
        if (bus.req[w] !== 1'b1) begin
          failures++;
          $display("FAIL rnd_gnt_noreq c%0d: gnt=%b req=%b", cyc, bus.gnt, bus.req);
        end
        ill = cs[w] && cr[w];
        want_err = ill ? bus.gnt : 4'b0;
        checks++;
        if (bus.err !== want_err) begin
          failures++;
          $display("FAIL rnd_err c%0d: err=%b, want %b", cyc, bus.err, want_err);
        end
        if (!ill && (cs[w] ^ cr[w])) model[ci[w]] = cs[w];
        bus.req[w] = 1'b0;
        waitc[w] = 0;
      end
      checks++;
      if (bus.q !== model) begin
        failures++;
        $display("FAIL rnd_q c%0d: q=%h, want %h", cyc, bus.q, model);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i]) begin
          waitc[i]++;
          checks++;
          if (waitc[i] > 12) begin
            failures++;
            $display("FAIL rnd_starve r%0d c%0d: waited %0d cycles, limit 12", i, cyc, waitc[i]);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          cs[i] = 1'($urandom_range(0, 1));
          cr[i] = 1'($urandom_range(0, 1));
          ci[i] = int'($urandom_range(0, 7));
          set_cmd(i, cs[i], cr[i], ci[i]);
          waitc[i] = 0;
        end
      end
    end
    bus.req = '0;
    tick(); tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    test_reset();
    test_basic();
    test_illegal();
    test_round_robin();
    test_reset_mid_apply();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
